// File: rtl/mux4_scan_sequencer_if.sv
// mux4_scan_sequencer_if: control, mux select/capture and sample-stream signals of the scan sequencer
interface mux4_scan_sequencer_if #(parameter int DWELL_W = 4);
    logic               start;
    logic               stop;
    logic [3:0]         chan_en;
    logic [DWELL_W-1:0] dwell;
    logic               mux_out;
    logic               s1;
    logic               s0;
    logic [3:0]         sample_data;
    logic [1:0]         sample_chan;
    logic               sample_valid;
    logic               scan_done;
    logic               busy;
    modport master (
        output start, stop, chan_en, dwell, mux_out,
        input  s1, s0, sample_data, sample_chan, sample_valid, scan_done, busy
    );
    modport slave (
        input  start, stop, chan_en, dwell, mux_out,
        output s1, s0, sample_data, sample_chan, sample_valid, scan_done, busy
    );
endinterface

// File: rtl/mux4_scan_sequencer.sv
// mux4_scan_sequencer: round-robin 4:1 mux scanner with programmable dwell and registered snapshot
module mux4_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    mux4_scan_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;
    state_t             state_q;
    logic [1:0]         sel_q;
    logic [1:0]         chan_q;
    logic [3:0]         data_q;
    logic               valid_q;
    logic               done_q;
    logic               busy_q;
    logic               pend_q;
    logic [DWELL_W-1:0] d_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [3:0]         above;
    logic [1:0]         first_ch;
    logic [1:0]         next_ch;
    logic               last_ch;
    logic               halt;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    // enabled channels strictly above the current one decide both wrap and scan_done
    assign above    = bus.chan_en & (4'b1110 << sel_q);
    assign first_ch = lowest(bus.chan_en);
    assign next_ch  = |above ? lowest(above) : first_ch;
    assign last_ch  = ~|above;
    assign halt     = pend_q | bus.stop | ~|bus.chan_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            chan_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            d_q     <= DWELL_W'(1);
            cnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.stop && |bus.chan_en) begin
                        d_q     <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                        sel_q   <= first_ch;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    pend_q  <= pend_q | bus.stop;
                    cnt_q   <= d_q;
                    state_q <= DWELL;
                end
                DWELL: begin
                    if (cnt_q != DWELL_W'(1)) begin
                        pend_q <= pend_q | bus.stop;
                        cnt_q  <= cnt_q - 1'b1;
                    end else begin
                        data_q[sel_q] <= bus.mux_out;
                        chan_q        <= sel_q;
                        valid_q       <= 1'b1;
                        done_q        <= last_ch;
                        // a stop seen on the capture edge itself still ends the scan here
                        if (halt) begin
                            busy_q  <= 1'b0;
                            pend_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            sel_q   <= next_ch;
                            state_q <= SETTLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s1           = sel_q[1];
    assign bus.s0           = sel_q[0];
    assign bus.sample_data  = data_q;
    assign bus.sample_chan  = chan_q;
    assign bus.sample_valid = valid_q;
    assign bus.scan_done    = done_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// tb_mux4_scan_sequencer: scoreboard bench for the mux scan sequencer
module tb_mux4_scan_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   s;
    logic [3:0] mux_in;

    typedef struct {
        int         at;
        logic [1:0] chan;
        logic [3:0] data;
        logic       done;
        logic [1:0] sel;
        logic       busy;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux4_scan_sequencer_if #(.DWELL_W(4)) bus();
    assign bus.mux_out = mux_in[{bus.s1, bus.s0}];

    mux4_scan_sequencer #(.DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push(input int at, input logic [1:0] ch, input logic [3:0] d,
                        input logic dn, input logic [1:0] sl, input logic b);
        sb.push_back('{at, ch, d, dn, sl, b});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic start_scan(input logic [3:0] m, input logic [3:0] dw, output int st);
        bus.chan_en = m;
        bus.dwell   = dw;
        bus.start   = 1'b1;
        st          = cyc;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.sample_valid) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.at);
                check("sample_chan", bus.sample_chan, e.chan);
                check("sample_data", bus.sample_data, e.data);
                check("scan_done", bus.scan_done, e.done);
                check("sel_after", {bus.s1, bus.s0}, e.sel);
                check("busy_after", bus.busy, e.busy);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: cycle %0d still running, limit reached", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.chan_en = 4'b0; bus.dwell = 4'd0;
        mux_in = 4'b0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_sel", {bus.s1, bus.s0}, 0);
        check("rst_data", bus.sample_data, 0);
        check("rst_valid", {bus.sample_valid, bus.scan_done, bus.sample_chan}, 0);
        rst_n = 1'b1;
        step();
        // full scan, dwell 2
        mux_in = 4'b1101;
        start_scan(4'b1111, 4'd2, s);
        check("full_sel0", {bus.s1, bus.s0}, 0);
        check("full_busy", bus.busy, 1);
        push(s+4, 2'd0, 4'b0001, 0, 2'd1, 1);
        push(s+7, 2'd1, 4'b0001, 0, 2'd2, 1);
        push(s+10, 2'd2, 4'b0101, 0, 2'd3, 1);
        push(s+13, 2'd3, 4'b1101, 1, 2'd0, 1);
        push(s+16, 2'd0, 4'b1101, 0, 2'd0, 0);
        wait_cyc(s+14);
        pulse_stop();
        wait_cyc(s+20);
        check("full_idle", bus.busy, 0);
        // sparse mask, dwell 0 acts as 1
        mux_in = 4'b0110;
        start_scan(4'b1010, 4'd0, s);
        check("sparse_sel0", {bus.s1, bus.s0}, 1);
        push(s+3, 2'd1, 4'b1111, 0, 2'd3, 1);
        push(s+5, 2'd3, 4'b0111, 1, 2'd1, 1);
        push(s+7, 2'd1, 4'b0111, 0, 2'd1, 0);
        wait_cyc(s+6);
        pulse_stop();
        wait_cyc(s+12);
        check("sparse_idle", bus.busy, 0);
        // stop in 2nd dwell cycle of channel 2, dwell 5
        mux_in = 4'b0000;
        start_scan(4'b0100, 4'd5, s);
        check("stop_sel", {bus.s1, bus.s0}, 2);
        push(s+7, 2'd2, 4'b0011, 1, 2'd2, 0);
        wait_cyc(s+3);
        pulse_stop();
        wait_cyc(s+6);
        check("stop_still_busy", bus.busy, 1);
        wait_cyc(s+20);
        check("stop_idle", bus.busy, 0);
        // mask change mid-dwell on channel 1, then single-channel repeat
        mux_in = 4'b1100;
        start_scan(4'b1111, 4'd3, s);
        push(s+5, 2'd0, 4'b0010, 0, 2'd1, 1);
        push(s+9, 2'd1, 4'b0000, 1, 2'd0, 1);
        push(s+13, 2'd0, 4'b0000, 1, 2'd0, 1);
        push(s+17, 2'd0, 4'b0001, 1, 2'd0, 1);
        push(s+21, 2'd0, 4'b0001, 1, 2'd0, 0);
        wait_cyc(s+7);
        bus.chan_en = 4'b0001;
        wait_cyc(s+14);
        mux_in = 4'b0001;
        wait_cyc(s+18);
        pulse_stop();
        wait_cyc(s+24);
        check("mask_idle", bus.busy, 0);
        // ignored starts
        start_scan(4'b0000, 4'd3, s);
        wait_cyc(s+4);
        check("nomask_busy", bus.busy, 0);
        check("nomask_sel", {bus.s1, bus.s0}, 0);
        bus.chan_en = 4'b0001;
        bus.stop = 1'b1;
        start_scan(4'b0001, 4'd3, s);
        bus.stop = 1'b0;
        wait_cyc(s+4);
        check("startstop_busy", bus.busy, 0);
        check("startstop_sel", {bus.s1, bus.s0}, 0);
        // async reset mid-dwell with sample_data 1011
        mux_in = 4'b1011;
        start_scan(4'b1111, 4'd1, s);
        push(s+3, 2'd0, 4'b0001, 0, 2'd1, 1);
        push(s+5, 2'd1, 4'b0011, 0, 2'd2, 1);
        push(s+7, 2'd2, 4'b0011, 0, 2'd3, 1);
        push(s+9, 2'd3, 4'b1011, 1, 2'd0, 1);
        wait_cyc(s+10);
        check("pre_rst_data", bus.sample_data, 4'b1011);
        check("pre_rst_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_sel", {bus.s1, bus.s0}, 0);
        check("arst_data", bus.sample_data, 0);
        check("arst_flags", {bus.sample_valid, bus.scan_done, bus.sample_chan}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_busy", bus.busy, 0);
        check("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mux4_scan_sequencer.md
Name: mux4_scan_sequencer

Overview:
- Drives the s1/s0 select lines of the 4-to-1 multiplexer and captures its single-bit output.
- Scans the enabled input channels in round-robin order, holding each channel for a programmable dwell time before sampling it.
- Presents a registered 4-bit snapshot of all channels, plus per-sample and per-round strobes, to downstream logic.

Parameters:
- DWELL_W, 4, width of the dwell-count input. Maximum dwell is 2^DWELL_W-1 cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin continuous scanning; honoured only in IDLE
- stop  input  1  request end of scanning after the current channel's capture
- chan_en  input  4  channel enable mask; bit k enables mux input ik
- dwell  input  DWELL_W  cycles to hold each channel; 0 is treated as 1; latched on accepted start
- mux_out  input  1  output of the 4-to-1 multiplexer
- s1  output  1  mux select MSB (registered)
- s0  output  1  mux select LSB (registered)
- sample_data  output  4  last captured value per channel; bit k = channel k
- sample_chan  output  2  channel index of the most recent capture
- sample_valid  output  1  one-cycle pulse: sample_data[sample_chan] was just updated
- scan_done  output  1  one-cycle pulse, coincident with sample_valid, on capture of the highest-index enabled channel
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - State goes to IDLE.
  - s1, s0, sample_data, sample_chan, sample_valid, scan_done and busy all go to 0.
  - Pending-stop flag is cleared.
  - Latched dwell is 1.
- FSM states: IDLE, SETTLE, DWELL.
- IDLE:
  - start=1, stop=0, chan_en!=0: at the next edge, latch D = max(dwell,1).
  - Load {s1,s0} with the lowest-index enabled channel, go to SETTLE, set busy=1.
  - start with chan_en=0: ignored, stay in IDLE.
  - start and stop in the same cycle: stop wins, stay in IDLE.
- SETTLE:
  - Lasts exactly 1 cycle; this is the mux propagation allowance.
  - Then go to DWELL and load the dwell counter with D.
- DWELL:
  - Lasts exactly D cycles.
  - On the edge ending the last DWELL cycle:
    - sample_data[cur] <= mux_out, sample_chan <= cur, sample_valid <= 1 for one cycle.
    - scan_done <= 1 if cur is the highest-index bit set in chan_en at that edge.
    - Next channel = next set bit of chan_en above cur, wrapping to the lowest set bit. Evaluate chan_en at this edge.
    - If pending stop, or chan_en==0: go to IDLE, busy=0, s1/s0 hold their last value.
    - Otherwise: load {s1,s0} with the next channel and go to SETTLE.
- Timing:
  - Channel period = 1+D cycles.
  - First sample_valid appears 2+D cycles after the start cycle.
- Stop:
  - stop=1 in any non-IDLE cycle sets the pending flag.
  - The scan always completes the current channel's capture; it is never truncated.
  - The pending flag clears on entry to IDLE.
- Only-one-channel enabled: scan re-selects the same channel. sample_valid and scan_done pulse every 1+D cycles.
- chan_en changes mid-dwell do not affect the current channel.
- dwell changes after start are ignored until the next start.
- sample_data bits for disabled channels retain their previous value.

Test Plan:
- Reset mid-scan: assert rst_n=0 during DWELL with sample_data=4'b1011 -> all outputs 0 immediately, with no clock edge required.
- Full scan, chan_en=4'b1111, dwell=2, inputs i0..i3=1,0,1,1 -> s1s0 sequence 00,01,10,11,00.
  - sample_valid every 3 cycles; first pulse 4 cycles after start.
  - sample_data=4'b1101 after the 4th pulse, with scan_done coincident with sample_chan=3.
- Sparse mask, chan_en=4'b1010, dwell=0 -> selects alternate 01,11,01.
  - Period 2 cycles; scan_done only when sample_chan=3.
  - sample_data bits 0 and 2 unchanged.
- Stop mid-dwell on channel 2 (dwell=5), stop pulsed in the 2nd DWELL cycle -> channel 2 still captured after its full 5 cycles.
  - Then busy=0 and state IDLE; no further sample_valid.
- Start with chan_en=0, and start+stop together with chan_en=4'b0001 -> busy stays 0 and s1s0 stay 00 in both cases.
- Mask change mid-dwell: chan_en 4'b1111 -> 4'b0001 while on channel 1 -> channel 1 is captured.
  - Next selection wraps to channel 0.
  - scan_done asserts with the channel 1 capture, since 1 exceeds the highest new bit, 0.
